// File: rtl/sobel_window_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen
//  Description : Pixel-stream front end for the Sobel edge detector.
//                Accepts one 8-bit grey pixel per handshake. Each pixel is
//                written, together with the previous line's pixel in the same
//                column, into an external line-delay memory at a wrapping
//                column address. The two older lines come back from the
//                memory's registered read port. A 3x3 neighbourhood is
//                assembled, and one registered window is emitted per pixel
//                that has a full neighbourhood. The output has backpressure.
//
//  Ports       : clk        - sole clock, rising edge
//                rst_n      - synchronous, active-low reset
//                pix_valid  - input pixel present
//                pix_data   - input pixel (8 bits)
//                pix_ready  - pixel accepted when pix_valid && pix_ready
//                mem_we     - line-delay memory write enable
//                mem_addr   - line-delay memory write address (column)
//                mem_wdata  - {16'h0, line row-1 pixel, current pixel}
//                mem_rdata  - registered read data; [7:0] holds line row-1,
//                             [15:8] holds line row-2, for column mem_addr
//                win_valid  - window present
//                win_ready  - downstream accepts the window
//                win_data   - 3x3 window; pixel (r,c) at [8*(3r+c) +: 8],
//                             r=0 top row, c=0 left column
//                win_last   - window belongs to the last pixel of the frame
//
//  Parameters  : LINE_LEN   - pixels per line (3..128); equals memory depth
//                FRAME_ROWS - lines per frame (3..1023)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
    parameter int LINE_LEN   = 78,
    parameter int FRAME_ROWS = 58
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        mem_we,
    output logic [6:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [71:0] win_data,
    output logic        win_last
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_COL_LAST = 7'(LINE_LEN - 1);
    localparam logic [9:0] c_ROW_LAST = 10'(FRAME_ROWS - 1);
    localparam logic [6:0] c_COL_MIN  = 7'd2;
    localparam logic [9:0] c_ROW_MIN  = 10'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [6:0]            r_col;
    logic [9:0]            r_row;
    // r_win[r][c]: row r (0 = top), column c (0 = left), one byte each.
    logic [2:0][2:0][7:0]  r_win;
    logic                  r_win_valid;
    logic                  r_win_last;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic                  w_acc;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_emit;
    logic [2:0][7:0]       w_right;
    logic                  w_unused_rdata;

    // The only thing that can block input is an unretired window. Keeping
    // pix_ready independent of pix_valid avoids a combinational loop upstream.
    assign pix_ready  = !r_win_valid || win_ready;
    assign w_acc      = pix_valid && pix_ready;

    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);

    // Columns 0-1 still hold the tail of the previous line after the shift.
    // Rows 0-1 read memory that was not written in this frame. Neither can
    // form a true neighbourhood.
    assign w_emit     = (r_row >= c_ROW_MIN) && (r_col >= c_COL_MIN);

    // New right-hand column. The oldest line is on top; the live pixel is on
    // the bottom.
    assign w_right[0] = mem_rdata[15:8];
    assign w_right[1] = mem_rdata[7:0];
    assign w_right[2] = pix_data;

    // The upper half of the read word is never written with live data.
    assign w_unused_rdata = ^mem_rdata[31:16];

    // ------------------------------------------------------------------------
    // Line-delay memory drive
    // ------------------------------------------------------------------------
    // The address holds through stalls. The memory's registered read word
    // therefore keeps describing the current column until the next accept.
    assign mem_addr  = r_col;
    assign mem_we    = w_acc;
    // The previous line's pixel is pushed one slot up. When this column is
    // next read, it appears as the line two rows back.
    assign mem_wdata = {16'h0000, mem_rdata[7:0], pix_data};

    // ------------------------------------------------------------------------
    // Column / row counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? 10'd0 : (r_row + 10'd1);
            end else begin
                r_col <= r_col + 7'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Window shift register
    // ------------------------------------------------------------------------
    // The window register is also the output data register. It changes only
    // on accept, so it is stable whenever a window is held for backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (w_acc) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
                r_win[r][2] <= w_right[r];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output valid / last
    // ------------------------------------------------------------------------
    // An accept always reloads the output stage. Any window that retires in
    // the same cycle is replaced without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (w_acc) begin
            r_win_valid <= w_emit;
            r_win_last  <= w_row_last && w_col_last;
        end else if (r_win_valid && win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Output packing: pixel (r,c) -> win_data[8*(3r+c) +: 8]
    // ------------------------------------------------------------------------
    for (genvar gr = 0; gr < 3; gr++) begin : g_pack_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_pack_col
            assign win_data[8*(3*gr+gc) +: 8] = r_win[gr][gc];
        end
    end

    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;

endmodule
`default_nettype wire
